// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-pass handshaked logical shifter built on a combinational barrel shifter.
// Each pass applies min(remaining, MAXSTEP) positions, MAXSTEP = 2**(NLAYERS-1)-1.
// Optional feature macro: SHIFT_SEQ_SAT_EN -- amounts >= N short-circuit to a zero result at accept.

// Combinational logical barrel shifter: layer i shifts by 2**i when ctrl[i] is set.
module barrel_shifter #(
    parameter int unsigned N          = 8,
    parameter int unsigned NLAYERS    = 3,
    parameter bit          SHIFT_LEFT = 1'b0
) (
    input  logic [N-1:0]       in,
    input  logic [NLAYERS-1:0] ctrl,
    output logic [N-1:0]       out
);

    // Cascade the shift layers; vacated bits fill with zero.
    always_comb begin
        out = in;
        for (int i = 0; i < int'(NLAYERS); i++) begin
            if (ctrl[i]) begin
                out = SHIFT_LEFT ? (out << (1 << i)) : (out >> (1 << i));
            end
        end
    end

endmodule

module shift_sequencer #(
    parameter int unsigned N       = 8,
    parameter int unsigned NLAYERS = 3,
    parameter int unsigned AW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic          in_left,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy
);

    localparam int unsigned MaxStep = (2 ** (NLAYERS - 1)) - 1;
    localparam int unsigned SW      = NLAYERS - 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  d_q, d_d;
    logic [AW-1:0] r_q, r_d;
    logic          dir_q, dir_d;

    logic [SW-1:0]      step;
    logic [AW-1:0]      r_rem;
    logic [NLAYERS-1:0] ctrl;
    logic [N-1:0]       shr_out, shl_out, shifted;

`ifdef SHIFT_SEQ_SAT_EN
    // Widened so that N == 2**AW still compares correctly.
    localparam logic [AW:0] NLimit = (AW + 1)'(N);
`endif

    // Per-pass step is the remaining amount clamped to what one barrel pass covers.
    always_comb begin
        if (r_q > AW'(MaxStep)) begin
            step = SW'(MaxStep);
        end else begin
            step = r_q[SW-1:0];
        end
        r_rem = r_q - AW'(step);
        ctrl  = {1'b0, step};
    end

    barrel_shifter #(
        .N          (N),
        .NLAYERS    (NLAYERS),
        .SHIFT_LEFT (1'b0)
    ) u_shr (
        .in   (d_q),
        .ctrl (ctrl),
        .out  (shr_out)
    );

    barrel_shifter #(
        .N          (N),
        .NLAYERS    (NLAYERS),
        .SHIFT_LEFT (1'b1)
    ) u_shl (
        .in   (d_q),
        .ctrl (ctrl),
        .out  (shl_out)
    );

    assign shifted = dir_q ? shl_out : shr_out;

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        dir_d   = dir_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    d_d   = in_data;
                    r_d   = in_amt;
                    dir_d = in_left;
`ifdef SHIFT_SEQ_SAT_EN
                    if ({1'b0, in_amt} >= NLimit) begin
                        d_d     = '0;
                        r_d     = '0;
                        state_d = StDone;
                    end else if (in_amt == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
`else
                    if (in_amt == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
`endif
                end
            end
            StShift: begin
                d_d = shifted;
                r_d = r_rem;
                if (r_rem == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            d_q     <= '0;
            r_q     <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            dir_q   <= dir_d;
        end
    end

    // Handshake and status outputs are pure state decodes.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StShift);
        out_data  = d_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (N=8, NLAYERS=3, AW=4).
// Honours SHIFT_SEQ_SAT_EN for the expected latency of oversize amounts.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [3:0] in_amt = '0;
    logic       in_left = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] amt;
        logic       left;
        logic [7:0] exp_data;
        int         passes;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         passes;
    } exp_t;

    exp_t sb[$];

`ifdef SHIFT_SEQ_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    shift_sequencer #(
        .N       (8),
        .NLAYERS (3),
        .AW      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_left   (in_left),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: logical shift and pass count.
    function automatic logic [7:0] model_data(input logic [7:0] d, input logic [3:0] a,
                                              input logic l);
        logic [7:0] r;
        r = l ? (d << a) : (d >> a);
        return r;
    endfunction

    function automatic int model_passes(input logic [3:0] a);
        if (SatEn && a >= 4'd8) return 0;
        return (int'(a) + 2) / 3;
    endfunction

    // Issue one request, wait for the result, score it; optionally complete the output handshake.
    task automatic run_req(input string name, input logic [7:0] d, input logic [3:0] a,
                           input logic l, input logic [7:0] exp_d, input int exp_p,
                           input bit release_out);
        int   cycles;
        int   busy_cnt;
        exp_t e;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_left  = l;
        sb.push_back('{data: exp_d, passes: exp_p});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h5A;
        cycles   = 0;
        busy_cnt = 0;
        while (!out_valid && cycles < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.timeout: got no out_valid, required out_valid within 40 cycles", name);
            return;
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.scoreboard: got result, required pending expectation", name);
            return;
        end
        e = sb.pop_front();
        check({name, ".data"}, 32'(out_data), 32'(e.data));
        check({name, ".latency"}, 32'(cycles), 32'(e.passes));
        check({name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.passes));
        check({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
        if (release_out) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({name, ".out_valid_after"}, 32'(out_valid), 32'd0);
            check({name, ".in_ready_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{data: 8'hB4, amt: 4'd0,  left: 1'b0, exp_data: 8'hB4, passes: 0};
        vecs[1] = '{data: 8'hB4, amt: 4'd5,  left: 1'b0, exp_data: 8'h05, passes: 2};
        vecs[2] = '{data: 8'h81, amt: 4'd7,  left: 1'b1, exp_data: 8'h80, passes: 3};
        vecs[3] = '{data: 8'hFF, amt: 4'd12, left: 1'b1, exp_data: 8'h00,
                    passes: (SatEn ? 0 : 4)};
        vecs[4] = '{data: 8'h3C, amt: 4'd3,  left: 1'b1, exp_data: 8'hE0, passes: 1};

        // Reset state
        #2;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].left,
                    vecs[i].exp_data, vecs[i].passes, 1'b1);
        end

        // Random requests against the model
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic [3:0] a;
            logic       l;
            d = 8'($urandom);
            a = 4'($urandom_range(0, 15));
            l = 1'($urandom);
            run_req($sformatf("rnd%0d", i), d, a, l, model_data(d, a, l), model_passes(a), 1'b1);
        end

        // Backpressure: result held, new request blocked until output handshake
        run_req("bp", 8'h0F, 4'd2, 1'b0, 8'h03, 1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_amt   = 4'd1;
        in_left  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.hold_data", 32'(out_data), 32'h03);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_in_ready", 32'(in_ready), 32'd0);
            check("bp.hold_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.idle_in_ready", 32'(in_ready), 32'd1);
        check("bp.idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.accept_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("bp.new_valid", 32'(out_valid), 32'd1);
        check("bp.new_data", 32'(out_data), 32'hAA);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during the second SHIFT cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_amt   = 4'd15;
        in_left  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid.out_valid", 32'(out_valid), 32'd0);
        check("rmid.out_data", 32'(out_data), 32'd0);
        check("rmid.busy", 32'(busy), 32'd0);
        check("rmid.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("rmid.fresh", 8'h80, 4'd1, 1'b1, 8'h00, 1, 1'b1);

        check("sb.empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
